// File: rtl/rv_regfile_mp_sb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : rv_regfile_pkg
//  Purpose  : Shared types and constants for the multi-port register file
//             with pending-write scoreboard (address width, RV32E/RV32I
//             register counts, address legality helper).
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package rv_regfile_pkg;

  localparam int REG_ADDR_W  = 5;
  localparam int RV32E_NREGS = 16;
  localparam int RV32I_NREGS = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  // An address is legal when it names an implemented architectural register.
  function automatic logic is_legal(input reg_addr_t addr, input int nregs);
    return (int'(addr) < nregs);
  endfunction

endpackage
`default_nettype wire

// File: rtl/rv_regfile_mp_sb_if.sv
`default_nettype none
// ============================================================================
//  Module   : rv_regfile_mp_sb_if
//  Purpose  : Decode/issue/writeback bundle of the register file.
//  Ports    : rs_addr/rs_data/rs_busy   read ports (packed, port i at slice i)
//             iss_valid/iss_rd          issue of a destination register
//             wb_valid/wb_addr/wb_data  writeback ports (packed)
//             err_illegal               registered illegal-address pulse
//             master = decode/writeback side, slave = register file
//  Revision : 1.0  initial release
// ============================================================================
interface rv_regfile_mp_sb_if
  import rv_regfile_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NRP  = 2,
  parameter int NWP  = 2
);
  logic [NRP*REG_ADDR_W-1:0] rs_addr;
  logic [NRP*XLEN-1:0]       rs_data;
  logic [NRP-1:0]            rs_busy;
  logic                      iss_valid;
  reg_addr_t                 iss_rd;
  logic [NWP-1:0]            wb_valid;
  logic [NWP*REG_ADDR_W-1:0] wb_addr;
  logic [NWP*XLEN-1:0]       wb_data;
  logic                      err_illegal;

  modport master (
    output rs_addr, iss_valid, iss_rd, wb_valid, wb_addr, wb_data,
    input  rs_data, rs_busy, err_illegal
  );

  modport slave (
    input  rs_addr, iss_valid, iss_rd, wb_valid, wb_addr, wb_data,
    output rs_data, rs_busy, err_illegal
  );
endinterface
`default_nettype wire

// File: rtl/rv_regfile_mp_sb_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module   : rv_regfile_scoreboard
//  Purpose  : Per-register busy (pending write) tracking. Issue sets, any
//             writeback clears, issue wins when both hit the same register.
//             Busy lookup per read port.
//  Ports    : clk, rst_n (async, active-low)
//             iss_valid, iss_rd          set request
//             wb_valid, wb_addr          clear requests
//             rs_addr -> rs_busy         combinational busy lookup
//  Config   : REGFILE_BYPASS_EN hides busy of registers cleared this cycle
//  Revision : 1.0  initial release
// ============================================================================
module rv_regfile_scoreboard
  import rv_regfile_pkg::*;
#(
  parameter int NREGS = 32,
  parameter int NRP   = 2,
  parameter int NWP   = 2
) (
  input  wire logic                      clk,
  input  wire logic                      rst_n,
  input  wire logic                      iss_valid,
  input  wire reg_addr_t                 iss_rd,
  input  wire logic [NWP-1:0]            wb_valid,
  input  wire logic [NWP*REG_ADDR_W-1:0] wb_addr,
  input  wire logic [NRP*REG_ADDR_W-1:0] rs_addr,
  output logic [NRP-1:0]                 rs_busy
);

  logic [NREGS-1:0] r_busy;
  logic [NREGS-1:0] w_set;
  logic [NREGS-1:0] w_clr;
  logic [NREGS-1:0] w_view;

  // Decoding against every implemented register (from x1 up) keeps x0 and
  // out-of-range addresses from ever touching the busy vector.
  always_comb begin
    w_set = '0;
    w_clr = '0;
    for (int r = 1; r < NREGS; r++) begin
      w_set[r] = iss_valid && (iss_rd == REG_ADDR_W'(r));
      for (int p = 0; p < NWP; p++) begin
        if (wb_valid[p] && (wb_addr[p*REG_ADDR_W +: REG_ADDR_W] == REG_ADDR_W'(r))) begin
          w_clr[r] = 1'b1;
        end
      end
    end
  end

  // Set applied after clear: the issued instruction is younger.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= '0;
    end else begin
      r_busy <= (r_busy & ~w_clr) | w_set;
    end
  end

`ifdef REGFILE_BYPASS_EN
  assign w_view = r_busy & ~w_clr;
`else
  assign w_view = r_busy;
`endif

  always_comb begin
    rs_busy = '0;
    for (int p = 0; p < NRP; p++) begin
      for (int r = 1; r < NREGS; r++) begin
        if (rs_addr[p*REG_ADDR_W +: REG_ADDR_W] == REG_ADDR_W'(r)) begin
          rs_busy[p] = w_view[r];
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/rv_regfile_mp_sb.sv
`default_nettype none
// ============================================================================
//  Module   : rv_regfile_mp_sb
//  Purpose  : Parametrised multi-port integer register file (RV32E/RV32I)
//             with pending-write scoreboard and illegal-address flag.
//  Ports    : clk            clock, all state on posedge
//             rst_n          asynchronous active-low reset
//             bus (slave)    read ports, issue, writeback ports, err_illegal
//  Params   : XLEN, NREGS (16|32), NRP (1..4), NWP (1..2, higher idx wins)
//  Config   : REGFILE_BYPASS_EN - combinational write-through from the
//             writeback ports to the read ports
//  Revision : 1.0  initial release
// ============================================================================
module rv_regfile_mp_sb
  import rv_regfile_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NREGS = RV32I_NREGS,
  parameter int NRP   = 2,
  parameter int NWP   = 2
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  rv_regfile_mp_sb_if.slave      bus
);

  logic [XLEN-1:0]     r_regs [NREGS];
  logic [NRP*XLEN-1:0] w_rs_data;
  logic                w_illegal;
  logic                r_err;

  // Storage. Ports are visited in ascending order so the highest-index
  // valid port has the last say on a shared address. x0 is never written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREGS; r++) begin
        r_regs[r] <= '0;
      end
    end else begin
      for (int r = 1; r < NREGS; r++) begin
        for (int p = 0; p < NWP; p++) begin
          if (bus.wb_valid[p] &&
              (bus.wb_addr[p*REG_ADDR_W +: REG_ADDR_W] == REG_ADDR_W'(r))) begin
            r_regs[r] <= bus.wb_data[p*XLEN +: XLEN];
          end
        end
      end
    end
  end

  // Read mux; x0 and out-of-range addresses fall through to zero.
  always_comb begin
    w_rs_data = '0;
    for (int p = 0; p < NRP; p++) begin
      for (int r = 1; r < NREGS; r++) begin
        if (bus.rs_addr[p*REG_ADDR_W +: REG_ADDR_W] == REG_ADDR_W'(r)) begin
          w_rs_data[p*XLEN +: XLEN] = r_regs[r];
`ifdef REGFILE_BYPASS_EN
          // Forwarding is gated by rst_n so reads stay zero during reset.
          for (int q = 0; q < NWP; q++) begin
            if (rst_n && bus.wb_valid[q] &&
                (bus.wb_addr[q*REG_ADDR_W +: REG_ADDR_W] == REG_ADDR_W'(r))) begin
              w_rs_data[p*XLEN +: XLEN] = bus.wb_data[q*XLEN +: XLEN];
            end
          end
`endif
        end
      end
    end
  end

  assign bus.rs_data = w_rs_data;

  rv_regfile_scoreboard #(
    .NREGS (NREGS),
    .NRP   (NRP),
    .NWP   (NWP)
  ) u_scoreboard (
    .clk       (clk),
    .rst_n     (rst_n),
    .iss_valid (bus.iss_valid),
    .iss_rd    (bus.iss_rd),
    .wb_valid  (bus.wb_valid),
    .wb_addr   (bus.wb_addr),
    .rs_addr   (bus.rs_addr),
    .rs_busy   (bus.rs_busy)
  );

  // Read addresses are always live, so any out-of-range read flags; issue
  // and writeback addresses only count when their valid is asserted.
  always_comb begin
    w_illegal = bus.iss_valid && !is_legal(bus.iss_rd, NREGS);
    for (int p = 0; p < NRP; p++) begin
      if (!is_legal(bus.rs_addr[p*REG_ADDR_W +: REG_ADDR_W], NREGS)) begin
        w_illegal = 1'b1;
      end
    end
    for (int q = 0; q < NWP; q++) begin
      if (bus.wb_valid[q] && !is_legal(bus.wb_addr[q*REG_ADDR_W +: REG_ADDR_W], NREGS)) begin
        w_illegal = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else begin
      r_err <= w_illegal;
    end
  end

  assign bus.err_illegal = r_err;

endmodule
`default_nettype wire

// File: tb/tb_rv_regfile_mp_sb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rv_regfile_mp_sb
//  Purpose  : Self-checking bench for rv_regfile_mp_sb. One RV32I instance
//             (NREGS=32) checked against a reference model through an
//             expected-value queue, plus one RV32E instance (NREGS=16) for
//             illegal-address handling.
//  Revision : 1.0  initial release
// ============================================================================
module tb_rv_regfile_mp_sb;
  import rv_regfile_pkg::*;

  localparam int XLEN = 32;
  localparam int NRP  = 2;
  localparam int NWP  = 2;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rv_regfile_mp_sb_if #(.XLEN(XLEN), .NRP(NRP), .NWP(NWP)) bus   ();
  rv_regfile_mp_sb_if #(.XLEN(XLEN), .NRP(NRP), .NWP(NWP)) bus_e ();

  rv_regfile_mp_sb #(.XLEN(XLEN), .NREGS(RV32I_NREGS), .NRP(NRP), .NWP(NWP)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  rv_regfile_mp_sb #(.XLEN(XLEN), .NREGS(RV32E_NREGS), .NRP(NRP), .NWP(NWP)) u_dut_e (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_e)
  );

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } sb_item_t;

  sb_item_t    sb_q [$];
  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] m_regs [32];
  logic [31:0] m_busy;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [31:0] v);
    sb_item_t it;
    it.tag = tag;
    it.exp = v;
    sb_q.push_back(it);
  endtask

  task automatic sb_pop(input logic [31:0] got);
    sb_item_t it;
    if (sb_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL sb_empty: got 0x%08h expected none queued", got);
    end else begin
      it = sb_q.pop_front();
      check_val(it.tag, got, it.exp);
    end
  endtask

  function automatic logic [31:0] exp_data(input logic [4:0] a);
    logic [31:0] d;
    d = (a == 5'd0) ? 32'd0 : m_regs[a];
    if (BYP && a != 5'd0) begin
      for (int p = 0; p < NWP; p++) begin
        if (bus.wb_valid[p] && bus.wb_addr[5*p +: 5] == a) d = bus.wb_data[32*p +: 32];
      end
    end
    return d;
  endfunction

  function automatic logic [31:0] exp_busy(input logic [4:0] a);
    logic b;
    b = m_busy[a];
    if (BYP) begin
      for (int p = 0; p < NWP; p++) begin
        if (bus.wb_valid[p] && bus.wb_addr[5*p +: 5] == a) b = 1'b0;
      end
    end
    return {31'd0, b};
  endfunction

  task automatic model_reset();
    for (int r = 0; r < 32; r++) m_regs[r] = 32'd0;
    m_busy = 32'd0;
  endtask

  task automatic model_update();
    logic [31:0] clr;
    logic [4:0]  a;
    clr = 32'd0;
    for (int p = 0; p < NWP; p++) begin
      if (bus.wb_valid[p]) begin
        a = bus.wb_addr[5*p +: 5];
        if (a != 5'd0) m_regs[a] = bus.wb_data[32*p +: 32];
        clr[a] = 1'b1;
      end
    end
    m_busy = m_busy & ~clr;
    if (bus.iss_valid) m_busy[bus.iss_rd] = 1'b1;
    m_busy[0] = 1'b0;
  endtask

  task automatic set_in(input logic [4:0] r0, input logic [4:0] r1,
                        input logic iv, input logic [4:0] rd,
                        input logic [1:0] wv,
                        input logic [4:0] w0, input logic [31:0] d0,
                        input logic [4:0] w1, input logic [31:0] d1);
    bus.rs_addr   = {r1, r0};
    bus.iss_valid = iv;
    bus.iss_rd    = rd;
    bus.wb_valid  = wv;
    bus.wb_addr   = {w1, w0};
    bus.wb_data   = {d1, d0};
  endtask

  // One clock on the RV32I instance: queue expectations for the inputs
  // already driven, compare on the falling edge, then advance the model.
  task automatic step();
    logic [4:0] a;
    for (int p = 0; p < NRP; p++) begin
      a = bus.rs_addr[5*p +: 5];
      sb_push($sformatf("rs_data%0d_x%0d", p, a), exp_data(a));
      sb_push($sformatf("rs_busy%0d_x%0d", p, a), exp_busy(a));
    end
    sb_push("err_illegal", 32'd0);
    @(negedge clk);
    for (int p = 0; p < NRP; p++) begin
      sb_pop(bus.rs_data[32*p +: 32]);
      sb_pop({31'd0, bus.rs_busy[p]});
    end
    sb_pop({31'd0, bus.err_illegal});
    @(posedge clk);
    model_update();
    #1;
  endtask

  // One clock on the RV32E instance (port 0 write only).
  task automatic e_cycle(input logic [4:0] r0, input logic [4:0] r1,
                         input logic iv, input logic [4:0] rd,
                         input logic wv, input logic [4:0] wa, input logic [31:0] wd,
                         input logic [31:0] exp_d0, input logic exp_b0, input logic exp_err);
    bus_e.rs_addr   = {r1, r0};
    bus_e.iss_valid = iv;
    bus_e.iss_rd    = rd;
    bus_e.wb_valid  = {1'b0, wv};
    bus_e.wb_addr   = {5'd0, wa};
    bus_e.wb_data   = {32'd0, wd};
    sb_push($sformatf("e_rs_data0_x%0d", r0), exp_d0);
    sb_push($sformatf("e_rs_busy0_x%0d", r0), {31'd0, exp_b0});
    sb_push("e_err_illegal", {31'd0, exp_err});
    @(negedge clk);
    sb_pop(bus_e.rs_data[31:0]);
    sb_pop({31'd0, bus_e.rs_busy[0]});
    sb_pop({31'd0, bus_e.err_illegal});
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_reset();
    set_in(5'd0, 5'd0, 1'b0, 5'd0, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
    bus_e.rs_addr = '0; bus_e.iss_valid = 1'b0; bus_e.iss_rd = '0;
    bus_e.wb_valid = '0; bus_e.wb_addr = '0; bus_e.wb_data = '0;

    // Outputs while reset is held.
    #12;
    set_in(5'd5, 5'd31, 1'b0, 5'd0, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
    #1;
    check_val("rst_rs_data0", bus.rs_data[31:0], 32'd0);
    check_val("rst_rs_data1", bus.rs_data[63:32], 32'd0);
    check_val("rst_rs_busy", {30'd0, bus.rs_busy}, 32'd0);
    check_val("rst_err", {31'd0, bus.err_illegal}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // All registers read zero after reset.
    for (int a = 0; a < 32; a++) begin
      set_in(5'(a), 5'(31 - a), 1'b0, 5'd0, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
      step();
    end

    // Single write, then read back next cycle.
    set_in(5'd5, 5'd0, 1'b0, 5'd0, 2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'd0);
    step();
    set_in(5'd5, 5'd0, 1'b0, 5'd0, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
    step();

    // Same-address dual write (port 1 wins), write to x0 ignored.
    set_in(5'd7, 5'd0, 1'b0, 5'd0, 2'b11, 5'd7, 32'h11, 5'd7, 32'h22);
    step();
    set_in(5'd7, 5'd0, 1'b0, 5'd0, 2'b01, 5'd0, 32'hFFFFFFFF, 5'd0, 32'd0);
    step();
    set_in(5'd7, 5'd0, 1'b0, 5'd0, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
    step();

    // Scoreboard: issue, issue+writeback, writeback alone, issue to x0.
    set_in(5'd9, 5'd0, 1'b1, 5'd9, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
    step();
    set_in(5'd9, 5'd0, 1'b1, 5'd9, 2'b10, 5'd0, 32'd0, 5'd9, 32'h99);
    step();
    set_in(5'd9, 5'd0, 1'b0, 5'd0, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
    step();
    set_in(5'd9, 5'd0, 1'b0, 5'd0, 2'b01, 5'd9, 32'h1234, 5'd0, 32'd0);
    step();
    set_in(5'd9, 5'd0, 1'b1, 5'd0, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
    step();
    set_in(5'd9, 5'd0, 1'b0, 5'd0, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
    step();

    // Random traffic on a narrow address window to provoke collisions.
    for (int i = 0; i < 80; i++) begin
      set_in(5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)),
             1'($urandom_range(0, 1)), 5'($urandom_range(0, 15)),
             2'($urandom_range(0, 3)),
             5'($urandom_range(0, 15)), $urandom(),
             5'($urandom_range(0, 15)), $urandom());
      step();
    end

    // Asynchronous reset mid-stream, with a write pending in that cycle.
    set_in(5'd12, 5'd13, 1'b1, 5'd13, 2'b01, 5'd12, 32'hA5A5A5A5, 5'd0, 32'd0);
    step();
    set_in(5'd12, 5'd13, 1'b0, 5'd0, 2'b10, 5'd0, 32'd0, 5'd14, 32'hCAFEF00D);
    #2;
    check_val("pre_rst_x12", bus.rs_data[31:0], exp_data(5'd12));
    check_val("pre_rst_busy_x13", {31'd0, bus.rs_busy[1]}, exp_busy(5'd13));
    rst_n = 1'b0;
    #1;
    check_val("async_rst_x12", bus.rs_data[31:0], 32'd0);
    check_val("async_rst_x13", bus.rs_data[63:32], 32'd0);
    check_val("async_rst_busy", {30'd0, bus.rs_busy}, 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    set_in(5'd12, 5'd14, 1'b0, 5'd0, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step();
    set_in(5'd13, 5'd5, 1'b0, 5'd0, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
    step();

    // RV32E instance: out-of-range accesses.
    e_cycle(5'd20, 5'd4, 1'b0, 5'd0,  1'b1, 5'd20, 32'h12345678, 32'd0, 1'b0, 1'b0);
    e_cycle(5'd4,  5'd3, 1'b0, 5'd0,  1'b0, 5'd0,  32'd0,        32'd0, 1'b0, 1'b1);
    e_cycle(5'd4,  5'd3, 1'b1, 5'd17, 1'b0, 5'd0,  32'd0,        32'd0, 1'b0, 1'b0);
    e_cycle(5'd1,  5'd3, 1'b0, 5'd0,  1'b0, 5'd0,  32'd0,        32'd0, 1'b0, 1'b1);
    e_cycle(5'd20, 5'd3, 1'b0, 5'd0,  1'b0, 5'd0,  32'd0,        32'd0, 1'b0, 1'b0);
    e_cycle(5'd15, 5'd3, 1'b0, 5'd0,  1'b0, 5'd25, 32'd0,        32'd0, 1'b0, 1'b1);
    e_cycle(5'd15, 5'd3, 1'b0, 5'd0,  1'b1, 5'd15, 32'h5A,
            BYP ? 32'h5A : 32'd0, 1'b0, 1'b0);
    e_cycle(5'd15, 5'd3, 1'b0, 5'd0,  1'b0, 5'd0,  32'd0,        32'h5A, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
